timer1_service_master: RTL and testbench

TIMER1_SERVICE_MASTER -- requirements
Module: timer1_service_master

---
 rtl/timer1_service_master_if.sv | 25 ++
 rtl/timer1_service_master.sv | 115 +++++++++++
 tb/tb_timer1_service_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer1_service_master_if.sv
// Register-slave bus between the timer service master and the timer peripheral.
// readdata is registered by the slave on every clock edge.
interface timer1_service_master_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/timer1_service_master.sv
// Services a memory-mapped interval timer: enables its interrupt, acknowledges timeouts,
// counts real and spurious interrupts, and issues period reloads on request.
module timer1_service_master (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           reload_req,
  input  logic                           irq,
  timer1_service_master_if.master        bus,
  output logic                           tick,
  output logic [31:0]                    tick_count,
  output logic [7:0]                     spurious_count,
  output logic                           busy
);

  typedef enum logic [2:0] {
    StIdle, StInitWr, StWaitIrq, StRdStat, StRdCap, StClrWr, StReloadWr, StDisWr
  } state_e;

  state_e      state_q, state_d;
  logic        reload_pend_q, reload_pend_d;
  logic        cs_q, cs_d, wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        tick_q, tick_d, busy_q, busy_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [7:0]  spur_q, spur_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (enable) state_d = StInitWr;
      StInitWr:   state_d = StWaitIrq;
      StWaitIrq: begin
        if (!enable)            state_d = StDisWr;
        else if (irq)           state_d = StRdStat;
        else if (reload_pend_q) state_d = StReloadWr;
      end
      StRdStat:   state_d = StRdCap;
      StRdCap:    state_d = StClrWr;
      StClrWr:    state_d = StWaitIrq;
      StReloadWr: state_d = StWaitIrq;
      StDisWr:    state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Bus strobes are registered from the next state, so they track state_q exactly.
  always_comb begin
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'h0000;
    unique case (state_d)
      StInitWr:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0001; end
      StRdStat:   begin cs_d = 1'b1; end
      StClrWr:    begin cs_d = 1'b1; wn_d = 1'b0; end
      StReloadWr: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; end
      StDisWr:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; end
      default:    ;
    endcase
  end

  always_comb begin
    busy_d        = !(state_d == StIdle || state_d == StWaitIrq);
    reload_pend_d = reload_req | (reload_pend_q & (state_q != StReloadWr));
    tick_d        = 1'b0;
    tick_count_d  = tick_count_q;
    spur_d        = spur_q;
    if (state_q == StRdCap) begin
      if (bus.readdata[0]) begin
        tick_d       = 1'b1;
        tick_count_d = tick_count_q + 32'd1;
      end else if (spur_q != 8'hFF) begin
        spur_d = spur_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      reload_pend_q <= 1'b0;
      cs_q          <= 1'b0;
      wn_q          <= 1'b1;
      addr_q        <= 3'd0;
      wdata_q       <= 16'h0000;
      tick_q        <= 1'b0;
      busy_q        <= 1'b0;
      tick_count_q  <= 32'd0;
      spur_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      reload_pend_q <= reload_pend_d;
      cs_q          <= cs_d;
      wn_q          <= wn_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tick_q        <= tick_d;
      busy_q        <= busy_d;
      tick_count_q  <= tick_count_d;
      spur_q        <= spur_d;
    end
  end

  assign bus.chipselect = cs_q;
  assign bus.write_n    = wn_q;
  assign bus.address    = addr_q;
  assign bus.writedata  = wdata_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign spurious_count = spur_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_timer1_service_master.sv
// Bench for timer1_service_master: behavioural timer slave, bus access log, and
// per-scenario checks against access sequences and counts derived from the timer's behaviour.
module tb_timer1_service_master;
  localparam int unsigned Period = 200;
  typedef logic [19:0] acc_t;  // {write_n, address, writedata (0 for reads)}

  logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, reload_req = 1'b0;
  logic        irq, tick, busy;
  logic [31:0] tick_count;
  logic [7:0]  spurious_count;

  timer1_service_master_if bus ();

  timer1_service_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .reload_req     (reload_req),
    .irq            (irq),
    .bus            (bus),
    .tick           (tick),
    .tick_count     (tick_count),
    .spurious_count (spurious_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Timer slave: TO at addr 0 (write clears), irq enable at addr 1, period_l at addr 2.
  logic        to_q, ien_q;
  int unsigned cnt_q, slave_timeouts;
  logic        timer_run = 1'b1, inject = 1'b0, spur = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= 1'b0; ien_q <= 1'b0; cnt_q <= Period - 1; slave_timeouts <= 0;
      bus.readdata <= 16'h0000;
    end else begin
      bus.readdata <= {15'b0, to_q & ~spur};
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: to_q <= 1'b0;
          3'd1: begin ien_q <= bus.writedata[0]; cnt_q <= Period - 1; end
          3'd2: cnt_q <= Period - 1;
          default: ;
        endcase
      end else if (ien_q && timer_run) begin
        if (cnt_q == 0) begin
          to_q <= 1'b1; cnt_q <= Period - 1; slave_timeouts <= slave_timeouts + 1;
        end else begin
          cnt_q <= cnt_q - 1;
        end
      end
      if (inject) to_q <= 1'b1;
    end
  end
  assign irq = spur | (to_q & ien_q);

  acc_t        log_q[$];
  acc_t        exp_q[$];
  int unsigned cs_b2b = 0, tick_wide = 0, tick_pulses = 0;
  logic        prev_cs = 1'b0, prev_tick = 1'b0;

  always @(negedge clk) begin
    if (reset_n && bus.chipselect)
      log_q.push_back({bus.write_n, bus.address, bus.write_n ? 16'h0000 : bus.writedata});
    if (bus.chipselect && prev_cs) cs_b2b++;
    if (tick && prev_tick) tick_wide++;
    if (tick && !prev_tick) tick_pulses++;
    prev_cs   = bus.chipselect;
    prev_tick = tick;
  end

  int errors = 0, checks = 0;

  function automatic acc_t wr(input logic [2:0] a, input logic [15:0] d);
    return {1'b0, a, d};
  endfunction
  function automatic acc_t rd(input logic [2:0] a);
    return {1'b1, a, 16'h0000};
  endfunction
  function automatic bit log_eq();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (log_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int unsigned count_acc(input acc_t a);
    int unsigned n = 0;
    foreach (log_q[i]) if (log_q[i] === a) n++;
    return n;
  endfunction

  task automatic quiesce();
    for (int k = 0; k < 100 && (busy || irq); k++) @(negedge clk);
    checks++;
    if (busy || irq) begin
      errors++; $display("FAIL quiesce: busy=%0b irq=%0b, required both 0", busy, irq);
    end
  endtask

  task automatic pulse_inject();
    @(negedge clk); inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0;
    @(negedge clk);
    checks += 8;
    if (bus.chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: %b want 0", bus.chipselect); end
    if (bus.write_n !== 1'b1) begin errors++; $display("FAIL rst_wn: %b want 1", bus.write_n); end
    if (bus.address !== 3'd0) begin errors++; $display("FAIL rst_addr: %h want 0", bus.address); end
    if (bus.writedata !== 16'h0) begin errors++; $display("FAIL rst_wdata: %h want 0", bus.writedata); end
    if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: %b want 0", tick); end
    if (tick_count !== 32'd0) begin errors++; $display("FAIL rst_tc: %0d want 0", tick_count); end
    if (spurious_count !== 8'd0) begin errors++; $display("FAIL rst_sp: %0d want 0", spurious_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b want 0", busy); end
  endtask

  task automatic test_init();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
    enable = 1'b1;
    @(negedge clk);
    checks += 2;
    if ({bus.chipselect, bus.write_n, bus.address, bus.writedata} !== {1'b1, 1'b0, 3'd1, 16'h0001}) begin
      errors++; $display("FAIL init_write: cs=%b wn=%b a=%h d=%h want 1 0 1 0001",
                         bus.chipselect, bus.write_n, bus.address, bus.writedata);
    end
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: %b want 1", busy); end
    repeat (3) @(negedge clk);
    exp_q = '{wr(3'd1, 16'h0001)};
    checks += 3;
    if (!log_eq()) begin errors++; $display("FAIL init_log: %0d accesses, want 1 write a1 d0001", log_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy: %b want 0", busy); end
    if (bus.chipselect !== 1'b0) begin errors++; $display("FAIL init_idle_cs: %b want 0", bus.chipselect); end
  endtask

  task automatic test_periodic();
    int unsigned tc0 = tick_count, tp0 = tick_pulses;
    log_q.delete();
    repeat (3 * Period + Period / 2) @(negedge clk);
    quiesce();
    exp_q = '{rd(3'd0), wr(3'd0, 16'h0), rd(3'd0), wr(3'd0, 16'h0), rd(3'd0), wr(3'd0, 16'h0)};
    checks += 3;
    if (!log_eq()) begin errors++; $display("FAIL periodic_log: %0d accesses, want 6", log_q.size()); end
    if (tick_count - tc0 !== 3) begin errors++; $display("FAIL periodic_tc: +%0d want +3", tick_count - tc0); end
    if (tick_pulses - tp0 !== 3) begin errors++; $display("FAIL periodic_ticks: %0d want 3", tick_pulses - tp0); end
  endtask

  task automatic test_random();
    int unsigned tc0 = tick_count, to0 = slave_timeouts, n_rel = 0, n_to;
    logic [7:0] sp0 = spurious_count;
    log_q.delete();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(10, 60)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        reload_req = 1'b1; @(negedge clk); reload_req = 1'b0; n_rel++;
      end
    end
    repeat (10) @(negedge clk);
    quiesce();
    n_to = slave_timeouts - to0;
    checks += 6;
    if (count_acc(rd(3'd0)) != n_to) begin
      errors++; $display("FAIL rand_reads: %0d want %0d", count_acc(rd(3'd0)), n_to); end
    if (count_acc(wr(3'd0, 16'h0)) != n_to) begin
      errors++; $display("FAIL rand_clears: %0d want %0d", count_acc(wr(3'd0, 16'h0)), n_to); end
    if (count_acc(wr(3'd2, 16'h0)) != n_rel) begin
      errors++; $display("FAIL rand_reloads: %0d want %0d", count_acc(wr(3'd2, 16'h0)), n_rel); end
    if (log_q.size() != 2 * n_to + n_rel) begin
      errors++; $display("FAIL rand_total: %0d want %0d", log_q.size(), 2 * n_to + n_rel); end
    if (tick_count - tc0 != n_to) begin
      errors++; $display("FAIL rand_tc: +%0d want +%0d", tick_count - tc0, n_to); end
    if (spurious_count !== sp0) begin
      errors++; $display("FAIL rand_sp: %0d want %0d", spurious_count, sp0); end
  endtask

  task automatic test_irq_reload();
    int unsigned tc0;
    timer_run = 1'b0;
    quiesce();
    tc0 = tick_count;
    log_q.delete();
    @(negedge clk); inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0; reload_req = 1'b1;
    @(posedge clk); #1 reload_req = 1'b0;
    repeat (15) @(negedge clk);
    exp_q = '{rd(3'd0), wr(3'd0, 16'h0), wr(3'd2, 16'h0)};
    checks += 2;
    if (!log_eq()) begin errors++; $display("FAIL irq_reload_order: %0d accesses, want rd0 wr0 wr2", log_q.size()); end
    if (tick_count - tc0 !== 1) begin errors++; $display("FAIL irq_reload_tc: +%0d want +1", tick_count - tc0); end
  endtask

  task automatic test_reload_collapse();
    log_q.delete();
    enable = 1'b0;
    repeat (4) @(negedge clk);
    exp_q = '{wr(3'd1, 16'h0)};
    checks += 1;
    if (!log_eq()) begin errors++; $display("FAIL disable_log: %0d accesses, want wr1 0000", log_q.size()); end
    log_q.delete();
    for (int i = 0; i < int'($urandom_range(2, 5)); i++) begin
      reload_req = 1'b1; @(negedge clk); reload_req = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    enable = 1'b1;
    repeat (10) @(negedge clk);
    exp_q = '{wr(3'd1, 16'h0001), wr(3'd2, 16'h0)};
    checks += 2;
    if (!log_eq()) begin errors++; $display("FAIL collapse_log: %0d accesses, want wr1 0001, wr2", log_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL collapse_busy: %b want 0", busy); end
  endtask

  task automatic test_spurious();
    int unsigned tc0 = tick_count, sp0 = spurious_count, n1 = $urandom_range(50, 200), nrd, want;
    log_q.delete();
    spur = 1'b1;
    for (int c = 0; c < 4000 && count_acc(rd(3'd0)) < n1; c++) @(negedge clk);
    spur = 1'b0;
    quiesce();
    nrd  = count_acc(rd(3'd0));
    want = (sp0 + nrd > 255) ? 255 : sp0 + nrd;
    checks += 1;
    if (spurious_count != want) begin errors++; $display("FAIL spur_partial: %0d want %0d", spurious_count, want); end
    spur = 1'b1;
    for (int c = 0; c < 4000 && count_acc(rd(3'd0)) < 300; c++) @(negedge clk);
    spur = 1'b0;
    quiesce();
    nrd  = count_acc(rd(3'd0));
    want = (sp0 + nrd > 255) ? 255 : sp0 + nrd;
    checks += 4;
    if (nrd < 300) begin errors++; $display("FAIL spur_services: %0d want >= 300", nrd); end
    if (spurious_count != want) begin errors++; $display("FAIL spur_sat: %0d want %0d", spurious_count, want); end
    if (count_acc(wr(3'd0, 16'h0)) != nrd) begin
      errors++; $display("FAIL spur_clears: %0d want %0d", count_acc(wr(3'd0, 16'h0)), nrd); end
    if (tick_count !== tc0) begin errors++; $display("FAIL spur_tc: %0d want %0d", tick_count, tc0); end
  endtask

  task automatic test_enable_drop();
    int unsigned tc0 = tick_count;
    log_q.delete();
    pulse_inject();
    for (int c = 0; c < 20 && !(bus.chipselect && bus.write_n); c++) @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    exp_q = '{rd(3'd0), wr(3'd0, 16'h0), wr(3'd1, 16'h0)};
    checks += 3;
    if (!log_eq()) begin errors++; $display("FAIL endrop_log: %0d accesses, want rd0 wr0 wr1", log_q.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL endrop_busy: %b want 0", busy); end
    if (tick_count - tc0 !== 1) begin errors++; $display("FAIL endrop_tc: +%0d want +1", tick_count - tc0); end
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    pulse_inject();
    for (int c = 0; c < 20 && !(bus.chipselect && !bus.write_n && bus.address == 3'd0); c++)
      @(negedge clk);
    reset_n = 1'b0; enable = 1'b0;
    #1;
    checks += 5;
    if (bus.chipselect !== 1'b0) begin errors++; $display("FAIL rstmid_cs: %b want 0", bus.chipselect); end
    if (tick !== 1'b0) begin errors++; $display("FAIL rstmid_tick: %b want 0", tick); end
    if (tick_count !== 32'd0) begin errors++; $display("FAIL rstmid_tc: %0d want 0", tick_count); end
    if (spurious_count !== 8'd0) begin errors++; $display("FAIL rstmid_sp: %0d want 0", spurious_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: %b want 0", busy); end
    @(negedge clk); reset_n = 1'b1;
    log_q.delete();
    repeat (6) @(negedge clk);
    checks += 1;
    if (log_q.size() != 0) begin errors++; $display("FAIL rstmid_resume: %0d accesses want 0", log_q.size()); end
  endtask

  task automatic test_bus_rules();
    checks += 2;
    if (cs_b2b != 0) begin errors++; $display("FAIL cs_back_to_back: %0d want 0", cs_b2b); end
    if (tick_wide != 0) begin errors++; $display("FAIL tick_width: %0d wide cycles want 0", tick_wide); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_periodic();
    test_random();
    test_irq_reload();
    test_reload_collapse();
    test_spurious();
    test_enable_drop();
    test_reset_mid();
    test_bus_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
